dmem_mmio_hub: RTL and testbench
================================

# dmem_mmio_hub

Data-memory hub placed between the processor's data-memory port and the data RAM. It decodes each word address into either RAM or a memory-mapped peripheral region. The peripheral region holds a MIDI-byte receive FIFO and NUM_VOICES synthesizer voice registers. All read data, from RAM or MMIO, returns with one fixed cycle of latency, so the processor sees a uniform memory.

## Interface
- DATA_W, 32, processor data word width
- ADDR_W, 12, word-address width; the MSB selects the region
- NUM_VOICES, 8, number of voice registers (1..16)
- FIFO_DEPTH, 16, MIDI FIFO depth; power of two, 2..256
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- cpu_addr  in  ADDR_W  word address from the processor
- cpu_wren  in  1  write strobe
- cpu_ren  in  1  read strobe; asserted only on load cycles
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid one cycle after cpu_ren
- ram_addr  out  ADDR_W-1  RAM word address (cpu_addr[ADDR_W-2:0])
- ram_wren  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data (cpu_wdata)
- ram_rdata  in  DATA_W  RAM read data, synchronous, one-cycle latency
- midi_valid  in  1  incoming MIDI byte valid
- midi_byte  in  8  incoming MIDI byte
- midi_ready  out  1  equals !full
- voice_en  out  NUM_VOICES  per-voice enable mask
- voice_inc  out  NUM_VOICES*DATA_W  phase increments; voice k occupies bits [k*DATA_W +: DATA_W]

## Operation
- Region decode:
  - cpu_addr[ADDR_W-1]=0 selects RAM.
  - Otherwise MMIO, using offset = cpu_addr[4:0].
- RAM region:
  - ram_wren = cpu_wren & RAM select.
  - ram_addr and ram_wdata are combinational pass-throughs.
- MMIO map, by offset:
  - 0 FIFO_DATA: read pops one byte, zero-extended. Writes are ignored.
  - 1 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[15:8] count, other bits 0. Writing 1 to bit2 or bit3 clears that bit (write-1-to-clear).
  - 2 VOICE_EN: read/write; the low NUM_VOICES bits are used and upper bits read 0.
  - 16..16+NUM_VOICES-1: voice_inc registers, read/write at full DATA_W.
  - Any other offset reads 0 and ignores writes.
- FIFO:
  - Circular buffer of FIFO_DEPTH x 8 bits with read and write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Push when midi_valid & !full.
  - Pop when cpu_ren at FIFO_DATA & !empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: midi_valid while full drops the byte and sets the overflow bit.
- Underflow: cpu_ren at FIFO_DATA while empty returns 0, sets the underflow bit, and leaves pointers unchanged.
- Simultaneous push and pop when non-empty: both occur and count is unchanged. When empty, only the push occurs and the pop is an underflow.
- Simultaneous cpu_wren and cpu_ren in one cycle is illegal and the processor never issues it. If it does occur, the write takes effect and the read returns the pre-write value.

## Timing
- Read latency is 1 cycle.
  - The hub registers the region select and the MMIO read value in the cycle cpu_ren is asserted.
  - In the next cycle, cpu_rdata = registered select ? registered MMIO value : ram_rdata.
- A FIFO pop takes effect at the edge ending the read cycle. The returned byte is the head of the FIFO before that pop.
- STATUS reads return the values from the read cycle, i.e. before that edge's push or pop.
- MMIO writes take effect at the edge ending the write cycle. voice_en and voice_inc update on that edge.
- midi_ready is combinational from the registered count.
- Reset (reset=0 at a rising edge), including mid-operation:
  - FIFO is emptied (pointers and count 0) and both sticky bits are cleared.
  - voice_en=0 and every voice_inc=0.
  - cpu_rdata=0 and the registered select=0.
  - midi_ready=1 from the first cycle after reset.
- FIFO storage contents are not reset. A push in the same cycle as reset is discarded.

## Test plan
- Reset, then push bytes 0x90, 0x3C, 0x7F; read FIFO_DATA three times -> cpu_rdata is 0x90, 0x3C, 0x7F, each one cycle after its read; STATUS then reads 0x0001.
- With FIFO_DEPTH=16, push 17 bytes -> midi_ready=0 after the 16th byte; the 17th byte is dropped; STATUS reads 0x1006. Write 0x4 to STATUS -> STATUS reads 0x1002.
- Read FIFO_DATA while empty -> returns 0 and STATUS bit3 is set. Write 0x8 to STATUS -> bit3 clears.
- Write 0x00012345 to offset 16+3 and 0x0B to VOICE_EN -> voice_inc slice 3 = 0x00012345, voice_en = 0x0B; reading both back returns the same values.
- Alternate RAM write/read at address 0x005 with MMIO reads -> RAM data (0xDEADBEEF) and MMIO data each appear exactly one cycle after their respective reads; the RAM never receives MMIO writes (ram_wren=0).
- Drive push and pop in the same cycle with count=5 -> count stays 5. Assert reset mid-stream -> count=0, voice outputs=0, midi_ready=1.

Source files
------------

// File: rtl/dmem_mmio_hub.sv
// dmem_mmio_hub: splits processor data accesses between RAM and an MMIO region (MIDI FIFO, voice registers)
module dmem_mmio_hub #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int NUM_VOICES = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic                         cpu_wren,
    input  logic                         cpu_ren,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic [ADDR_W-2:0]            ram_addr,
    output logic                         ram_wren,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic                         midi_valid,
    input  logic [7:0]                   midi_byte,
    output logic                         midi_ready,
    output logic [NUM_VOICES-1:0]        voice_en,
    output logic [NUM_VOICES*DATA_W-1:0] voice_inc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW > 8 ? 8 : CW;

    logic [7:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]         rptr, wptr;
    logic [CW-1:0]         count;
    logic                  ovf, udf, sel_q, ram_q;
    logic [DATA_W-1:0]     mv_q, rd, status;
    logic [DATA_W-1:0]     vinc [NUM_VOICES];
    logic                  mmio, empty, full, push, pop_req, pop, wr;
    logic [4:0]            off;

    assign mmio       = cpu_addr[ADDR_W-1];
    assign off        = cpu_addr[4:0];
    assign empty      = count == '0;
    assign full       = count == CW'(FIFO_DEPTH);
    assign push       = midi_valid & !full;
    assign pop_req    = cpu_ren & mmio & (off == 5'd0);
    assign pop        = pop_req & !empty;
    assign wr         = cpu_wren & mmio;
    assign midi_ready = !full;
    assign ram_addr   = cpu_addr[ADDR_W-2:0];
    assign ram_wren   = cpu_wren & !mmio;
    assign ram_wdata  = cpu_wdata;
    // outside a read's response cycle the bus is held at zero
    assign cpu_rdata  = sel_q ? mv_q : ram_q ? ram_rdata : '0;

    always_comb begin
        status = '0;
        status[3:0] = {udf, ovf, full, empty};
        status[8 +: SW] = count[SW-1:0];
        rd = '0;
        if (off == 5'd0) rd[7:0] = empty ? 8'h00 : mem[rptr];
        if (off == 5'd1) rd = status;
        if (off == 5'd2) rd[NUM_VOICES-1:0] = voice_en;
        for (int k = 0; k < NUM_VOICES; k++)
            if (off == 5'(16 + k)) rd = vinc[k];
    end

    always_comb begin
        voice_inc = '0;
        for (int k = 0; k < NUM_VOICES; k++)
            voice_inc[k*DATA_W +: DATA_W] = vinc[k];
    end

    always_ff @(posedge clock)
        if (reset && push) mem[wptr] <= midi_byte;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            sel_q    <= 1'b0;
            ram_q    <= 1'b0;
            mv_q     <= '0;
            voice_en <= '0;
            for (int k = 0; k < NUM_VOICES; k++) vinc[k] <= '0;
        end else begin
            sel_q <= cpu_ren & mmio;
            ram_q <= cpu_ren & !mmio;
            mv_q  <= rd;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            // a new event in the same cycle as a clear keeps the flag set
            ovf <= (midi_valid & full) | (ovf & !(wr && off == 5'd1 && cpu_wdata[2]));
            udf <= (pop_req & empty) | (udf & !(wr && off == 5'd1 && cpu_wdata[3]));
            if (wr && off == 5'd2) voice_en <= cpu_wdata[NUM_VOICES-1:0];
            for (int k = 0; k < NUM_VOICES; k++)
                if (wr && off == 5'(16 + k)) vinc[k] <= cpu_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_hub.sv
// tb_dmem_mmio_hub: directed stimulus against a queue-based model of the hub, plus literal expectations
module tb_dmem_mmio_hub;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NV = 8;
    localparam int FD = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [AW-1:0]     cpu_addr = '0;
    logic              cpu_wren = 1'b0;
    logic              cpu_ren = 1'b0;
    logic [DW-1:0]     cpu_wdata = '0;
    logic [DW-1:0]     cpu_rdata;
    logic [AW-2:0]     ram_addr;
    logic              ram_wren;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata = '0;
    logic              midi_valid = 1'b0;
    logic [7:0]        midi_byte = '0;
    logic              midi_ready;
    logic [NV-1:0]     voice_en;
    logic [NV*DW-1:0]  voice_inc;

    int checks = 0;
    int failures = 0;

    logic [7:0]    q[$];
    logic          m_ovf = 1'b0, m_udf = 1'b0, exp_rv = 1'b0, started = 1'b0;
    logic [NV-1:0] m_ven = '0;
    logic [DW-1:0] m_vinc [NV];
    logic [DW-1:0] m_ram [2048];
    logic [DW-1:0] sram [2048];
    logic [DW-1:0] exp_rd = '0;

    dmem_mmio_hub #(.DATA_W(DW), .ADDR_W(AW), .NUM_VOICES(NV), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_ren(cpu_ren), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .midi_valid(midi_valid), .midi_byte(midi_byte),
        .midi_ready(midi_ready), .voice_en(voice_en), .voice_inc(voice_inc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) sram[ram_addr] <= ram_wdata;
        ram_rdata <= sram[ram_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mmio_val(input int o);
        if (o == 0) return q.size() > 0 ? DW'(q[0]) : '0;
        if (o == 1) return (DW'(q.size()) << 8) | DW'({m_udf, m_ovf, q.size() == FD, q.size() == 0});
        if (o == 2) return DW'(m_ven);
        if (o >= 16 && o < 16 + NV) return m_vinc[o-16];
        return '0;
    endfunction

    task automatic model_edge();
        int o = int'(cpu_addr[4:0]);
        logic mm = cpu_addr[AW-1];
        int pre = q.size();
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_ven = '0;
            for (int k = 0; k < NV; k++) m_vinc[k] = '0;
            exp_rd = '0;
            exp_rv = 1'b1;
            started = 1'b1;
        end else begin
            exp_rv = cpu_ren;
            exp_rd = mm ? mmio_val(o) : m_ram[cpu_addr[10:0]];
            if (cpu_wren && !mm) m_ram[cpu_addr[10:0]] = cpu_wdata;
            if (cpu_wren && mm) begin
                if (o == 1 && cpu_wdata[2]) m_ovf = 1'b0;
                if (o == 1 && cpu_wdata[3]) m_udf = 1'b0;
                if (o == 2) m_ven = cpu_wdata[NV-1:0];
                if (o >= 16 && o < 16 + NV) m_vinc[o-16] = cpu_wdata;
            end
            if (cpu_ren && mm && o == 0) begin
                if (pre > 0) void'(q.pop_front());
                else m_udf = 1'b1;
            end
            if (midi_valid) begin
                if (pre < FD) q.push_back(midi_byte);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // model checked against every output on the falling edge
    always @(negedge clock) begin
        if (started) begin
            chk("midi_ready", DW'(midi_ready), DW'(q.size() < FD));
            chk("voice_en", DW'(voice_en), DW'(m_ven));
            for (int k = 0; k < NV; k++) chk("voice_inc", voice_inc[k*DW +: DW], m_vinc[k]);
            chk("ram_wren", DW'(ram_wren), DW'(cpu_wren & !cpu_addr[AW-1]));
            if (exp_rv) chk("cpu_rdata", cpu_rdata, exp_rd);
        end
    end

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cpu_addr = a;
        cpu_ren = 1'b1;
        cpu_wren = 1'b0;
        cyc();
        cpu_ren = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_addr = a;
        cpu_wdata = d;
        cpu_wren = 1'b1;
        cpu_ren = 1'b0;
        cyc();
        cpu_wren = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        midi_valid = 1'b1;
        midi_byte = b;
        cyc();
        midi_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NV; k++) m_vinc[k] = '0;
        for (int k = 0; k < 2048; k++) begin
            m_ram[k] = '0;
            sram[k] = '0;
        end
        cyc();
        cyc();
        chk("rst_ready", DW'(midi_ready), 32'h1);
        chk("rst_voice_en", DW'(voice_en), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        reset = 1'b1;

        push(8'h90);
        push(8'h3C);
        push(8'h7F);
        rd(12'h800); chk("fifo0", cpu_rdata, 32'h90);
        rd(12'h800); chk("fifo1", cpu_rdata, 32'h3C);
        rd(12'h800); chk("fifo2", cpu_rdata, 32'h7F);
        rd(12'h801); chk("status_empty", cpu_rdata, 32'h0001);

        for (int i = 0; i < 17; i++) begin
            push(8'(i + 1));
            if (i == 15) chk("ready_full", DW'(midi_ready), 32'h0);
        end
        rd(12'h801); chk("status_ovf", cpu_rdata, 32'h1006);
        wr(12'h801, 32'h4);
        rd(12'h801); chk("status_ovf_clr", cpu_rdata, 32'h1002);
        for (int i = 0; i < 16; i++) begin
            rd(12'h800);
            chk("drain", cpu_rdata, DW'(i + 1));
        end
        rd(12'h800); chk("underflow_data", cpu_rdata, 32'h0);
        rd(12'h801); chk("status_udf", cpu_rdata, 32'h0009);
        wr(12'h801, 32'h8);
        rd(12'h801); chk("status_udf_clr", cpu_rdata, 32'h0001);

        wr(12'h813, 32'h0001_2345);
        wr(12'h802, 32'h0B);
        chk("voice3_out", voice_inc[3*DW +: DW], 32'h0001_2345);
        chk("voice_en_out", DW'(voice_en), 32'h0B);
        rd(12'h813); chk("voice3_rd", cpu_rdata, 32'h0001_2345);
        rd(12'h802); chk("voice_en_rd", cpu_rdata, 32'h0B);
        rd(12'h81F); chk("unmapped_1f", cpu_rdata, 32'h0);
        rd(12'h818); chk("unmapped_18", cpu_rdata, 32'h0);

        wr(12'h005, 32'hDEAD_BEEF);
        rd(12'h005); chk("ram_rd0", cpu_rdata, 32'hDEAD_BEEF);
        rd(12'h802); chk("mmio_after_ram", cpu_rdata, 32'h0B);
        cpu_addr = 12'h805;
        cpu_wdata = 32'h1234_5678;
        cpu_wren = 1'b1;
        #1;
        chk("mmio_wr_no_ram", DW'(ram_wren), 32'h0);
        cyc();
        cpu_wren = 1'b0;
        wr(12'h810, 32'hFFFF_0000);
        rd(12'h005); chk("ram_rd1", cpu_rdata, 32'hDEAD_BEEF);
        rd(12'h813); chk("voice3_rd2", cpu_rdata, 32'h0001_2345);

        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        rd(12'h801); chk("count5", cpu_rdata, 32'h0500);
        midi_valid = 1'b1;
        midi_byte = 8'hB0;
        cpu_addr = 12'h800;
        cpu_ren = 1'b1;
        cyc();
        midi_valid = 1'b0;
        cpu_ren = 1'b0;
        chk("pushpop_data", cpu_rdata, 32'hA0);
        rd(12'h801); chk("pushpop_count", cpu_rdata, 32'h0500);

        midi_valid = 1'b1;
        midi_byte = 8'h55;
        reset = 1'b0;
        cyc();
        chk("midrst_voice_en", DW'(voice_en), 32'h0);
        chk("midrst_voice_inc", DW'(|voice_inc), 32'h0);
        chk("midrst_ready", DW'(midi_ready), 32'h1);
        chk("midrst_rdata", cpu_rdata, 32'h0);
        reset = 1'b1;
        midi_valid = 1'b0;
        rd(12'h801); chk("midrst_status", cpu_rdata, 32'h0001);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
